// File: rtl/delay_task_scheduler.sv
// Delayed-job scheduler: NUM_SLOTS countdown slots run in parallel and feed a
// one-entry completion register carrying id, issue delay and expiry timestamp.
module delay_task_scheduler #(
  parameter int NUM_SLOTS = 4,
  parameter int DLY_W     = 8,
  parameter int ID_W      = 4,
  parameter int TIME_W    = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [DLY_W-1:0]  req_delay,
  input  logic [ID_W-1:0]   req_id,
  output logic              done_valid,
  input  logic              done_ready,
  output logic [ID_W-1:0]   done_id,
  output logic [DLY_W-1:0]  done_delay,
  output logic [TIME_W-1:0] done_time,
  output logic              busy
);

  localparam int IDX_W = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_COUNT = 2'd1,
    S_PEND  = 2'd2
  } slot_state_t;

  slot_state_t       r_state [NUM_SLOTS];
  logic [ID_W-1:0]   r_id    [NUM_SLOTS];
  logic [DLY_W-1:0]  r_dly   [NUM_SLOTS];
  logic [DLY_W-1:0]  r_cnt   [NUM_SLOTS];
  logic [TIME_W-1:0] r_texp  [NUM_SLOTS];

  logic [TIME_W-1:0] r_time;
  logic              r_out_vld;
  logic [ID_W-1:0]   r_out_id;
  logic [DLY_W-1:0]  r_out_dly;
  logic [TIME_W-1:0] r_out_time;

  logic [NUM_SLOTS-1:0] w_idle;
  logic [NUM_SLOTS-1:0] w_expired;
  logic [NUM_SLOTS-1:0] w_grant;
  logic [NUM_SLOTS-1:0] w_take;
  logic [IDX_W-1:0]     w_alloc_idx;
  logic [IDX_W-1:0]     w_drain_idx;
  logic                 w_any_idle;
  logic                 w_any_expired;
  logic                 w_accept;
  logic                 w_out_free;
  logic                 w_load;

  // A COUNT slot at zero is already drainable so the minimum latency is
  // accept + delay + 2; if the output register is busy it parks in PEND.
  always_comb begin
    for (int i = 0; i < NUM_SLOTS; i++) begin
      w_idle[i]    = (r_state[i] == S_IDLE);
      w_expired[i] = (r_state[i] == S_PEND) ||
                     ((r_state[i] == S_COUNT) && (r_cnt[i] == '0));
    end
  end

  always_comb begin
    w_alloc_idx   = '0;
    w_any_idle    = 1'b0;
    w_drain_idx   = '0;
    w_any_expired = 1'b0;
    for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
      if (w_idle[i]) begin
        w_alloc_idx = IDX_W'(i);
        w_any_idle  = 1'b1;
      end
      if (w_expired[i]) begin
        w_drain_idx   = IDX_W'(i);
        w_any_expired = 1'b1;
      end
    end
  end

  assign w_accept   = req_valid && w_any_idle;
  assign w_out_free = !r_out_vld || done_ready;
  assign w_load     = w_out_free && w_any_expired;

  always_comb begin
    for (int i = 0; i < NUM_SLOTS; i++) begin
      w_grant[i] = w_accept && (w_alloc_idx == IDX_W'(i));
      w_take[i]  = w_load   && (w_drain_idx == IDX_W'(i));
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_SLOTS; i++) begin
        r_state[i] <= S_IDLE;
      end
    end else begin
      for (int i = 0; i < NUM_SLOTS; i++) begin
        case (r_state[i])
          S_IDLE: begin
            if (w_grant[i]) begin
              r_state[i] <= S_COUNT;
            end
          end
          S_COUNT: begin
            if (r_cnt[i] == '0) begin
              r_state[i] <= w_take[i] ? S_IDLE : S_PEND;
            end
          end
          S_PEND: begin
            if (w_take[i]) begin
              r_state[i] <= S_IDLE;
            end
          end
          default: r_state[i] <= S_IDLE;
        endcase
      end
    end
  end

  // Slot payload is only meaningful while the slot is non-IDLE.
  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_SLOTS; i++) begin
      if (w_grant[i]) begin
        r_id[i]   <= req_id;
        r_dly[i]  <= req_delay;
        r_cnt[i]  <= req_delay;
        r_texp[i] <= r_time + TIME_W'(req_delay) + TIME_W'(1);
      end else if ((r_state[i] == S_COUNT) && (r_cnt[i] != '0)) begin
        r_cnt[i]  <= r_cnt[i] - DLY_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_time     <= '0;
      r_out_vld  <= 1'b0;
      r_out_id   <= '0;
      r_out_dly  <= '0;
      r_out_time <= '0;
    end else begin
      r_time <= r_time + TIME_W'(1);
      if (w_load) begin
        r_out_vld  <= 1'b1;
        r_out_id   <= r_id[w_drain_idx];
        r_out_dly  <= r_dly[w_drain_idx];
        r_out_time <= r_texp[w_drain_idx];
      end else if (done_ready) begin
        r_out_vld  <= 1'b0;
      end
    end
  end

  assign req_ready  = w_any_idle;
  assign done_valid = r_out_vld;
  assign done_id    = r_out_id;
  assign done_delay = r_out_dly;
  assign done_time  = r_out_time;
  assign busy       = !(&w_idle) || r_out_vld;

endmodule

// File: doc/delay_task_scheduler.md
Name: delay_task_scheduler

Overview:
Synthesizable hardware counterpart of our concurrent-delayed-task benches. It accepts (delay, task-id) jobs into NUM_SLOTS independent countdown slots that run in parallel, in fork/join_none style. It emits one completion event per job on a valid/ready stream, carrying id, delay and completion timestamp. Completion order follows expiry time, not issue order. The completion stream feeds the downstream event logger/checker.

Parameters:
NUM_SLOTS, 4, number of concurrent job slots (2..16)
DLY_W, 8, width of job delay in cycles
ID_W, 4, width of task id
TIME_W, 16, width of free-running timestamp counter

Ports:
clk  in  1  clock; all state on rising edge
rst_n  in  1  asynchronous active-low reset
req_valid  in  1  job request valid
req_ready  out  1  scheduler can accept a job this cycle
req_delay  in  DLY_W  job delay in cycles
req_id  in  ID_W  job task id
done_valid  out  1  completion event valid
done_ready  in  1  downstream accepts event
done_id  out  ID_W  task id of completed job
done_delay  out  DLY_W  delay the job was issued with
done_time  out  TIME_W  timestamp at which the job expired
busy  out  1  any slot non-IDLE or output register full

Behaviour:
- Reset (rst_n low, async): all slots IDLE, output register empty, time_cnt=0. done_valid=0, done_id/done_delay/done_time=0, busy=0. req_ready=1 once reset is released. In-flight jobs are discarded with no event.
- time_cnt: 0 in first cycle after reset release, +1 every edge, wraps mod 2^TIME_W.
- Per-slot state machine: IDLE -> COUNT on accept; COUNT -> PEND on the edge where cnt==0, otherwise cnt-1; PEND -> IDLE on the edge its event is moved into the output register.
- Slot stores id, delay, cnt and t_exp. t_exp = T_acc+req_delay+1 mod 2^TIME_W, where T_acc is time_cnt in the accept cycle.
- req_ready = any slot IDLE at the start of the cycle, combinational from registered state only. It never depends on req_valid or on a same-cycle slot release.
- Accept occurs when req_valid&&req_ready. The job goes to the lowest-index IDLE slot, and cnt is loaded with req_delay.
- When req_ready=0, the request is not taken. The requester must hold it (standard valid/ready).
- Expiry timing: job accepted in cycle T_acc goes PEND after the edge ending cycle T_acc+req_delay. Delay 0 is legal and goes PEND one edge after accept.
- Output register (1 entry):
  - Loads when empty, or when full and done_valid&&done_ready in the same cycle.
  - Takes the lowest-index PEND slot and frees it on the same edge.
  - At most one load per edge.
  - Minimum latency is accept cycle T_acc to done_valid in cycle T_acc+req_delay+2.
- Outputs are driven from the output register. While done_valid&&!done_ready, all done_* fields hold stable. Events are never dropped or reordered once registered.
- Simultaneous expiries: all slots go PEND and drain lowest-index first, one per cycle. done_time of each is its own t_exp, not its drain time.
- Backpressure: slots in PEND stay PEND and their slots are not reusable. If all slots are in COUNT/PEND, req_ready=0.
- A slot freed on edge E is allocatable in the cycle after E.
- busy = any slot non-IDLE | output register full.

Test Plan:
1. Assert rst_n=0 for 3 cycles, then release -> done_valid=0, busy=0, req_ready=1, done_* fields=0.
2. With done_ready=1, issue (delay,id) = (30,1),(5,2),(10,3) in cycles 0,1,2 into slots 0,1,2.
   - Events arrive in order id2, id3, id1.
   - id2: done_time=7, done_valid in cycle 8. id3: done_time=13, cycle 14. id1: done_time=31, cycle 32.
   - busy=0 from cycle 33.
3. Fill all 4 slots with delay 20 -> req_ready=0 and a held 5th request (delay 0, id 9) is not taken. It is accepted the cycle after slot 0 is freed into the output register and lands in slot 0.
4. Issue id4 and id5 so both expire in the same cycle, in slots 1 and 0 -> id5 (slot 0) is presented first, id4 the next cycle, both carrying the identical done_time.
5. Backpressure: hold done_ready=0 for 10 cycles while 3 jobs expire.
   - First event is held stable for all 10 cycles.
   - After release, the 3 events drain on consecutive cycles in lowest-slot order with the correct done_time values.
6. Reset mid-operation: assert rst_n with 2 jobs counting and 1 event held -> done_valid drops immediately (async). No stale event appears after release, time_cnt restarts at 0, and a delay 0 job issued next completes with done_time=T_acc+1.
